// File: rtl/frame_buffer_reader.sv
// Raster-order read engine: scans the pixel RAM from address 0 and streams each word out over valid/ready.
// Define FRAME_BUFFER_READER_COORD_EN to carry per-pixel x/y tags on pixel_x_o/pixel_y_o.
module frame_buffer_reader #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 480,
  parameter int DATA_WIDTH = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  output logic [$clog2(COLUMNS*ROWS)-1:0]    ram_rd_address_o,
  output logic                               ram_rd_en_o,
  input  logic [DATA_WIDTH-1:0]              ram_rd_data_i,
  output logic [DATA_WIDTH-1:0]              pixel_data_o,
  output logic [$clog2(COLUMNS)-1:0]         pixel_x_o,
  output logic [$clog2(ROWS)-1:0]            pixel_y_o,
  output logic                               pixel_valid_o,
  input  logic                               pixel_ready_i,
  output logic                               busy_o,
  output logic                               frame_done_o
);

  localparam int AW = $clog2(COLUMNS*ROWS);
  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLUMNS-1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  logic            outstanding_reg;
  logic            frame_done_reg, frame_done_next;
  logic [1:0]      count_reg;
  logic            rd_ptr_reg, wr_ptr_reg;
  logic            rd_en;
  logic            push, pop;
  logic [2:0]      credit;

  assign pixel_valid_o = (count_reg != 2'd0);
  assign pop           = pixel_valid_o && pixel_ready_i;
  // Data for a read arrives exactly one cycle after issue, so the outstanding flag is the push strobe.
  assign push          = outstanding_reg;
  assign credit        = {1'b0, count_reg} + {2'b0, outstanding_reg} - {2'b0, pop};

  assign ram_rd_address_o = addr_reg;
  assign ram_rd_en_o      = rd_en;
  assign busy_o           = (state_reg != IDLE);
  assign frame_done_o     = frame_done_reg;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    frame_done_next = 1'b0;
    rd_en           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = READ;
          addr_next  = '0;
          x_next     = '0;
          y_next     = '0;
        end
      end
      READ: begin
        if (credit < 3'd2) begin
          rd_en = 1'b1;
          if (x_reg == X_LAST && y_reg == Y_LAST) begin
            state_next = DRAIN;
          end else begin
            addr_next = addr_reg + AW'(1);
            if (x_reg == X_LAST) begin
              x_next = '0;
              y_next = y_reg + YW'(1);
            end else begin
              x_next = x_reg + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        // Leave on the edge where the last word is handed over, so done and !busy appear together.
        if (!outstanding_reg && (count_reg == 2'd0 || (count_reg == 2'd1 && pop))) begin
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      outstanding_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      count_reg       <= 2'd0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      outstanding_reg <= rd_en;
      frame_done_reg  <= frame_done_next;
      count_reg       <= count_reg + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

`ifdef FRAME_BUFFER_READER_COORD_EN
  logic [XW-1:0] tag_x_reg;
  logic [YW-1:0] tag_y_reg;

  // Counters have already moved on when the data returns, so latch the issued coordinates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_x_reg <= '0;
      tag_y_reg <= '0;
    end else if (rd_en) begin
      tag_x_reg <= x_reg;
      tag_y_reg <= y_reg;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_q;
`ifdef FRAME_BUFFER_READER_COORD_EN
      logic [XW-1:0] x_q;
      logic [YW-1:0] y_q;
`endif
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          data_q <= '0;
`ifdef FRAME_BUFFER_READER_COORD_EN
          x_q    <= '0;
          y_q    <= '0;
`endif
        end else if (push && wr_ptr_reg == 1'(gi)) begin
          data_q <= ram_rd_data_i;
`ifdef FRAME_BUFFER_READER_COORD_EN
          x_q    <= tag_x_reg;
          y_q    <= tag_y_reg;
`endif
        end
      end
    end
  endgenerate

  assign pixel_data_o = rd_ptr_reg ? g_entry[1].data_q : g_entry[0].data_q;
`ifdef FRAME_BUFFER_READER_COORD_EN
  assign pixel_x_o = rd_ptr_reg ? g_entry[1].x_q : g_entry[0].x_q;
  assign pixel_y_o = rd_ptr_reg ? g_entry[1].y_q : g_entry[0].y_q;
`else
  assign pixel_x_o = '0;
  assign pixel_y_o = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench for frame_buffer_reader on a 4x3 frame with a behavioural RAM and pixel scoreboard.
module tb_frame_buffer_reader;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int DW   = 1;
  localparam int NPIX = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    ram_rd_address;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rd_data = '0;
  logic [DW-1:0] pixel_data;
  logic [1:0]    pixel_x;
  logic [1:0]    pixel_y;
  logic          pixel_valid;
  logic          pixel_ready = 1'b0;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int first_read, last_read, first_valid, last_xfer, done_cycle, done_count, early_reads, xfers, reads;
  logic [DW-1:0] ram [NPIX];

  frame_buffer_reader #(.COLUMNS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .ram_rd_address_o(ram_rd_address), .ram_rd_en_o(ram_rd_en), .ram_rd_data_i(ram_rd_data),
    .pixel_data_o(pixel_data), .pixel_x_o(pixel_x), .pixel_y_o(pixel_y),
    .pixel_valid_o(pixel_valid), .pixel_ready_i(pixel_ready),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rd_en && ram_rd_address < NPIX) ram_rd_data <= ram[ram_rd_address];
  end

  task automatic fill_ram(input bit rnd);
    for (int k = 0; k < NPIX; k++) begin
      int kk;
      kk = k;
      ram[k] = rnd ? DW'($urandom_range(0, 1)) : DW'(kk % 2);
    end
  endtask

  // mode 0: ready high, 1: ready toggles, 2: ready low for cycles 1..10, 3: random ready
  task automatic run_frame(input int mode, input bit poke);
    logic [DW-1:0] exp_d[$];
    int exp_x[$];
    int exp_y[$];
    int exp_i[$];
    bit r;
    for (int k = 0; k < NPIX; k++) begin
      exp_d.push_back(ram[k]);
      exp_i.push_back(k);
`ifdef FRAME_BUFFER_READER_COORD_EN
      exp_x.push_back(k % COLS);
      exp_y.push_back(k / COLS);
`else
      exp_x.push_back(0);
      exp_y.push_back(0);
`endif
    end
    first_read = -1; last_read = -1; first_valid = -1; last_xfer = -1;
    done_cycle = -1; done_count = 0; early_reads = 0; xfers = 0; reads = 0;
    start = 1'b1;
    pixel_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      case (mode)
        0: r = 1'b1;
        1: r = cyc[0];
        2: r = (cyc > 10);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pixel_ready = r;
      start = poke ? busy : 1'b0;
      #1;
      if (ram_rd_en) begin
        n_checks++;
        if (ram_rd_address !== 4'(reads)) begin
          n_fail++;
          $display("FAIL rd_address cycle %0d: got %0d expected %0d", cyc, ram_rd_address, reads);
        end
        if (first_read < 0) first_read = cyc;
        last_read = cyc;
        if (cyc <= 10) early_reads++;
        reads++;
      end
      if (pixel_valid) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++;
          $display("FAIL extra_pixel cycle %0d: got data %0h, expected no pixel", cyc, pixel_data);
        end else begin
          if (pixel_data !== exp_d[0] || pixel_x !== 2'(exp_x[0]) || pixel_y !== 2'(exp_y[0])) begin
            n_fail++;
            $display("FAIL pixel_%0d cycle %0d: got d=%0h x=%0d y=%0d expected d=%0h x=%0d y=%0d",
                     exp_i[0], cyc, pixel_data, pixel_x, pixel_y, exp_d[0], exp_x[0], exp_y[0]);
          end
          if (first_valid < 0) first_valid = cyc;
          if (r) begin
            $display("xfer pixel %0d data=%0h x=%0d y=%0d cycle=%0d", exp_i[0], pixel_data, pixel_x, pixel_y, cyc);
            void'(exp_d.pop_front()); void'(exp_x.pop_front());
            void'(exp_y.pop_front()); void'(exp_i.pop_front());
            xfers++;
            last_xfer = cyc;
          end
        end
      end
      n_checks++;
      if (reads - xfers > 2) begin
        n_fail++;
        $display("FAIL occupancy cycle %0d: got %0d words held/in flight, limit 2", cyc, reads - xfers);
      end
      if (frame_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_done cycle %0d: got %0b expected 0", cyc, busy);
        end
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    pixel_ready = 1'b0;
    n_checks++;
    if (done_count != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d expected 1", done_count);
    end
    n_checks++;
    if (xfers != NPIX || reads != NPIX) begin
      n_fail++;
      $display("FAIL frame_totals: got %0d xfers %0d reads expected %0d each", xfers, reads, NPIX);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ram_rd_address, ram_rd_en, pixel_data, pixel_x, pixel_y, pixel_valid, busy, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d en=%0b d=%0h x=%0d y=%0d v=%0b busy=%0b done=%0b expected all 0",
               ram_rd_address, ram_rd_en, pixel_data, pixel_x, pixel_y, pixel_valid, busy, frame_done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%0b en=%0b expected 0 0", busy, ram_rd_en);
    end
  endtask

  task automatic test_stream_timing;
    fill_ram(1'b0);
    run_frame(0, 1'b0);
    n_checks++;
    if (first_read != 1 || last_read != 12) begin
      n_fail++;
      $display("FAIL read_window: got cycles %0d..%0d expected 1..12", first_read, last_read);
    end
    n_checks++;
    if (first_valid != 3 || last_xfer != 14) begin
      n_fail++;
      $display("FAIL valid_window: got cycles %0d..%0d expected 3..14", first_valid, last_xfer);
    end
    n_checks++;
    if (done_cycle != 15) begin
      n_fail++;
      $display("FAIL done_cycle: got %0d expected 15", done_cycle);
    end
  endtask

  task automatic test_backpressure_toggle;
    fill_ram(1'b1);
    run_frame(1, 1'b0);
  endtask

  task automatic test_ready_low;
    fill_ram(1'b1);
    run_frame(2, 1'b0);
    n_checks++;
    if (early_reads != 2) begin
      n_fail++;
      $display("FAIL reads_while_stalled: got %0d expected 2", early_reads);
    end
  endtask

  task automatic test_start_ignored;
    fill_ram(1'b1);
    run_frame(3, 1'b1);
    fill_ram(1'b1);
    run_frame(0, 1'b0);
    n_checks++;
    if (first_read != 1) begin
      n_fail++;
      $display("FAIL second_frame_first_read: got cycle %0d expected 1", first_read);
    end
  endtask

  task automatic test_random_ready;
    for (int f = 0; f < 3; f++) begin
      fill_ram(1'b1);
      run_frame(3, 1'b0);
    end
  endtask

  task automatic test_reset_midframe;
    fill_ram(1'b0);
    start = 1'b1;
    pixel_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ram_rd_address, ram_rd_en, pixel_data, pixel_x, pixel_y, pixel_valid, busy, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got addr=%0d en=%0b d=%0h v=%0b busy=%0b done=%0b expected all 0",
               ram_rd_address, ram_rd_en, pixel_data, pixel_valid, busy, frame_done);
    end
    reset = 1'b0;
    pixel_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got valid=%0b busy=%0b expected 0 0", pixel_valid, busy);
    end
    fill_ram(1'b1);
    run_frame(0, 1'b0);
    n_checks++;
    if (first_read != 1 || done_cycle != 15) begin
      n_fail++;
      $display("FAIL fresh_frame: got first read %0d done %0d expected 1 15", first_read, done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_stream_timing();
    test_backpressure_toggle();
    test_ready_low();
    test_start_ignored();
    test_random_ready();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
